note_sequencer: RTL and testbench

NOTE_SEQUENCER -- requirements
Module: note_sequencer

---
 rtl/note_seq_pkg.sv | 37 +++
 rtl/tick_prescaler.sv | 34 +++
 rtl/note_sequencer.sv | 149 ++++++++++++++
 tb/tb_note_sequencer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/note_seq_pkg.sv
// ============================================================================
// Module  : note_seq_pkg
// Purpose : State encoding, song entry type and the constant song ROM.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package note_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_PLAY = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    typedef struct packed {
        logic [15:0] hp;
        logic [7:0]  dur;
    } entry_t;

    // hp = 0 is a rest; dur = 0 ends the song. Unlisted entries read as end markers.
    function automatic entry_t song_rom(input logic [7:0] idx);
        entry_t e;
        case (idx)
            8'd0:    e = '{hp: 16'd24999, dur: 8'd2};
            8'd1:    e = '{hp: 16'd0,     dur: 8'd1};
            8'd2:    e = '{hp: 16'd12499, dur: 8'd1};
            default: e = '{hp: 16'd0,     dur: 8'd0};
        endcase
        return e;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tick_prescaler.sv
// ============================================================================
// Module  : tick_prescaler
// Purpose : Emits a one-cycle tick every TICK_CYCLES clocks; clear restarts it.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tick_prescaler #(
    parameter int TICK_CYCLES = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    output logic o_tick
);

    localparam int             CNT_W  = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TICK_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || i_clear || (r_count == C_LAST)) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_tick = (r_count == C_LAST);

endmodule

`default_nettype wire

// File: rtl/note_sequencer.sv
// ============================================================================
// Module  : note_sequencer
// Purpose : Plays the song ROM note by note, driving a downstream tone generator.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module note_sequencer
    import note_seq_pkg::*;
#(
    parameter int TICK_CYCLES = 100000,
    parameter int GAP_TICKS   = 20,
    parameter int NUM_NOTES   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        loop_en,
    output logic [15:0] half_period,
    output logic        tone_en,
    output logic [7:0]  note_idx,
    output logic        busy,
    output logic        done
);

    localparam logic [7:0] C_LAST_IDX  = 8'(NUM_NOTES - 1);
    localparam logic [7:0] C_GAP_TICKS = 8'(GAP_TICKS);

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_ticks_left;
    logic [7:0]  w_ticks_next;
    logic [15:0] w_hp_next;
    logic        w_tone_next;
    logic [7:0]  w_idx_next;
    logic        w_tick;
    logic        w_last_note;
    state_t      w_adv_state;
    logic [7:0]  w_adv_idx;
    entry_t      w_entry;

    assign w_entry     = song_rom(note_idx);
    assign w_last_note = (note_idx == C_LAST_IDX);
    assign w_adv_state = (w_last_note && !loop_en) ? ST_DONE : ST_LOAD;
    assign w_adv_idx   = w_last_note ? 8'd0 : note_idx + 8'd1;

    // Any state change restarts the tick phase, so PLAY/GAP always begin at count 0.
    tick_prescaler #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .i_clear(w_state_next != r_state),
        .o_tick (w_tick)
    );

    always_comb begin
        w_state_next = r_state;
        w_hp_next    = half_period;
        w_tone_next  = tone_en;
        w_idx_next   = note_idx;
        w_ticks_next = r_ticks_left;
        case (r_state)
            ST_IDLE: begin
                if (start && !stop) begin
                    w_state_next = ST_LOAD;
                    w_idx_next   = 8'd0;
                end
            end
            ST_LOAD: begin
                if (w_entry.dur == 8'd0) begin
                    // Wrapping from index 0 would reload the same marker forever.
                    if (loop_en && (note_idx != 8'd0)) begin
                        w_idx_next = 8'd0;
                    end else begin
                        w_state_next = ST_DONE;
                    end
                end else begin
                    w_hp_next    = w_entry.hp;
                    w_tone_next  = (w_entry.hp != 16'd0);
                    w_ticks_next = w_entry.dur;
                    w_state_next = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (w_tick) begin
                    if (r_ticks_left > 8'd1) begin
                        w_ticks_next = r_ticks_left - 8'd1;
                    end else begin
                        w_tone_next = 1'b0;
                        if (GAP_TICKS != 0) begin
                            w_state_next = ST_GAP;
                            w_ticks_next = C_GAP_TICKS;
                        end else begin
                            w_state_next = w_adv_state;
                            w_idx_next   = w_adv_idx;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (w_tick) begin
                    if (r_ticks_left > 8'd1) begin
                        w_ticks_next = r_ticks_left - 8'd1;
                    end else begin
                        w_state_next = w_adv_state;
                        w_idx_next   = w_adv_idx;
                    end
                end
            end
            ST_DONE: begin
                w_tone_next  = 1'b0;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
                w_tone_next  = 1'b0;
            end
        endcase
        if (stop && (r_state != ST_IDLE)) begin
            w_state_next = ST_IDLE;
            w_tone_next  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_ticks_left <= 8'd0;
            half_period  <= 16'd0;
            tone_en      <= 1'b0;
            note_idx     <= 8'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_ticks_left <= w_ticks_next;
            half_period  <= w_hp_next;
            tone_en      <= w_tone_next;
            note_idx     <= w_idx_next;
            busy         <= (w_state_next != ST_IDLE);
            done         <= (w_state_next == ST_DONE);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_note_sequencer.sv
// ============================================================================
// Module  : tb_note_sequencer
// Purpose : Directed vector bench for note_sequencer with a short test song.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_note_sequencer;

    typedef struct packed {
        int          n;
        logic        rst;
        logic        start;
        logic        stop;
        logic        loop_en;
        logic        busy;
        logic        tone;
        logic [15:0] hp;
        logic [7:0]  idx;
        logic        done;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, start, stop, loop_en;
    logic        start2, loop2;
    logic [15:0] half_period, half_period2;
    logic        tone_en, tone_en2, busy, busy2, done, done2;
    logic [7:0]  note_idx, note_idx2;

    int checks = 0;
    int errors = 0;

    vec_t vecs [33];

    always #5 clk = ~clk;

    note_sequencer #(.TICK_CYCLES(4), .GAP_TICKS(1), .NUM_NOTES(16)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .loop_en(loop_en),
        .half_period(half_period), .tone_en(tone_en), .note_idx(note_idx),
        .busy(busy), .done(done)
    );

    // No gap and a 3-entry song: the last-index wrap path is reached before the marker.
    note_sequencer #(.TICK_CYCLES(4), .GAP_TICKS(0), .NUM_NOTES(3)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .stop(1'b0), .loop_en(loop2),
        .half_period(half_period2), .tone_en(tone_en2), .note_idx(note_idx2),
        .busy(busy2), .done(done2)
    );

    function automatic vec_t v(input int n, input logic r, input logic s, input logic p,
                               input logic l, input logic b, input logic t,
                               input logic [15:0] hp, input logic [7:0] idx, input logic d);
        vec_t x;
        x.n = n; x.rst = r; x.start = s; x.stop = p; x.loop_en = l;
        x.busy = b; x.tone = t; x.hp = hp; x.idx = idx; x.done = d;
        return x;
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
        start2 = 1'b0; loop2 = 1'b0;

        //             n  rst st sp lp  busy tone hp     idx done
        vecs[0]  = v(2,  1, 0, 0, 0,  0, 0, 16'd0,     8'd0, 0);
        vecs[1]  = v(1,  0, 1, 0, 0,  1, 0, 16'd0,     8'd0, 0);
        vecs[2]  = v(1,  0, 0, 0, 0,  1, 1, 16'd24999, 8'd0, 0);
        vecs[3]  = v(7,  0, 0, 0, 0,  1, 1, 16'd24999, 8'd0, 0);
        vecs[4]  = v(1,  0, 0, 0, 0,  1, 0, 16'd24999, 8'd0, 0);
        vecs[5]  = v(4,  0, 0, 0, 0,  1, 0, 16'd24999, 8'd1, 0);
        vecs[6]  = v(1,  0, 0, 0, 0,  1, 0, 16'd0,     8'd1, 0);
        vecs[7]  = v(9,  0, 0, 0, 0,  1, 1, 16'd12499, 8'd2, 0);
        vecs[8]  = v(3,  0, 0, 0, 0,  1, 1, 16'd12499, 8'd2, 0);
        vecs[9]  = v(1,  0, 0, 0, 0,  1, 0, 16'd12499, 8'd2, 0);
        vecs[10] = v(4,  0, 0, 0, 0,  1, 0, 16'd12499, 8'd3, 0);
        vecs[11] = v(1,  0, 0, 0, 0,  1, 0, 16'd12499, 8'd3, 1);
        vecs[12] = v(1,  0, 0, 0, 0,  0, 0, 16'd12499, 8'd3, 0);
        vecs[13] = v(3,  0, 0, 0, 0,  0, 0, 16'd12499, 8'd3, 0);
        vecs[14] = v(1,  0, 1, 0, 1,  1, 0, 16'd12499, 8'd0, 0);
        vecs[15] = v(31, 0, 0, 0, 1,  1, 0, 16'd12499, 8'd3, 0);
        vecs[16] = v(1,  0, 0, 0, 1,  1, 0, 16'd12499, 8'd0, 0);
        vecs[17] = v(1,  0, 0, 0, 1,  1, 1, 16'd24999, 8'd0, 0);
        vecs[18] = v(23, 0, 0, 0, 1,  1, 1, 16'd12499, 8'd2, 0);
        vecs[19] = v(1,  0, 1, 1, 1,  0, 0, 16'd12499, 8'd2, 0);
        vecs[20] = v(2,  0, 0, 0, 0,  0, 0, 16'd12499, 8'd2, 0);
        vecs[21] = v(1,  0, 1, 0, 0,  1, 0, 16'd12499, 8'd0, 0);
        vecs[22] = v(9,  0, 0, 0, 0,  1, 0, 16'd24999, 8'd0, 0);
        vecs[23] = v(1,  1, 0, 0, 0,  0, 0, 16'd0,     8'd0, 0);
        vecs[24] = v(1,  0, 1, 0, 0,  1, 0, 16'd0,     8'd0, 0);
        vecs[25] = v(1,  0, 0, 0, 0,  1, 1, 16'd24999, 8'd0, 0);
        vecs[26] = v(31, 0, 1, 0, 0,  1, 0, 16'd12499, 8'd3, 1);
        vecs[27] = v(1,  0, 1, 0, 0,  0, 0, 16'd12499, 8'd3, 0);
        vecs[28] = v(1,  0, 1, 0, 0,  1, 0, 16'd12499, 8'd0, 0);
        vecs[29] = v(1,  0, 1, 0, 0,  1, 1, 16'd24999, 8'd0, 0);
        vecs[30] = v(1,  0, 0, 1, 0,  0, 0, 16'd24999, 8'd0, 0);
        vecs[31] = v(2,  0, 1, 0, 0,  1, 1, 16'd24999, 8'd0, 0);
        vecs[32] = v(1,  1, 0, 0, 0,  0, 0, 16'd0,     8'd0, 0);

        for (int i = 0; i < 33; i++) begin
            reset = vecs[i].rst; start = vecs[i].start;
            stop = vecs[i].stop; loop_en = vecs[i].loop_en;
            step(vecs[i].n);
            check($sformatf("v%0d busy", i), int'(busy), int'(vecs[i].busy));
            check($sformatf("v%0d tone_en", i), int'(tone_en), int'(vecs[i].tone));
            check($sformatf("v%0d half_period", i), int'(half_period), int'(vecs[i].hp));
            check($sformatf("v%0d note_idx", i), int'(note_idx), int'(vecs[i].idx));
            check($sformatf("v%0d done", i), int'(done), int'(vecs[i].done));
        end
        reset = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
        step(1);

        // Gapless 3-note song, last index without loop: done right after note 2.
        start2 = 1'b1; loop2 = 1'b0;
        step(1);
        start2 = 1'b0;
        step(8);
        check("nl tone end of note0", int'(tone_en2), 1);
        step(1);
        check("nl load idx1", int'(note_idx2), 1);
        check("nl load tone", int'(tone_en2), 0);
        check("nl load busy", int'(busy2), 1);
        step(9);
        check("nl note2 hp", int'(half_period2), 12499);
        check("nl note2 tone", int'(tone_en2), 1);
        step(1);
        check("nl done pulse", int'(done2), 1);
        check("nl done busy", int'(busy2), 1);
        step(1);
        check("nl idle done", int'(done2), 0);
        check("nl idle busy", int'(busy2), 0);

        // Same song with looping: last index wraps to note 0, no done pulse.
        start2 = 1'b1; loop2 = 1'b1;
        step(1);
        start2 = 1'b0;
        step(19);
        check("lp wrap idx", int'(note_idx2), 0);
        check("lp wrap done", int'(done2), 0);
        check("lp wrap busy", int'(busy2), 1);
        step(1);
        check("lp replay hp", int'(half_period2), 24999);
        check("lp replay tone", int'(tone_en2), 1);
        loop2 = 1'b0;
        reset = 1'b1;
        step(1);
        check("lp reset tone", int'(tone_en2), 0);
        check("lp reset busy", int'(busy2), 0);
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
